// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline blocks: width math and lane packing.
package pipe_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // LSB of lane k inside a packed multi-lane word.
  function automatic int lane_lsb(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/pipe_elastic_stage.sv
// One elastic register slot: valid + multi-lane data, ready toward upstream.
module pipe_elastic_stage #(
  parameter int BITWIDTH = 8,
  parameter int LANES    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               src_valid,
  input  logic [LANES-1:0][BITWIDTH-1:0]     src_data,
  input  logic                               dst_ready,
  output logic                               valid,
  output logic [LANES-1:0][BITWIDTH-1:0]     data,
  output logic                               ready
);

  logic                           r_valid;
  logic [LANES-1:0][BITWIDTH-1:0] r_data;

  // An empty slot always accepts, so bubbles collapse toward the tail.
  assign ready = ~r_valid | dst_ready;
  assign valid = r_valid;
  assign data  = r_data;

  // Valid follows the source when ready; data only loads on a real word so
  // bubbles never toggle the data flops. Flush clears valid but keeps data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (ready) begin
      r_valid <= src_valid;
      if (src_valid) r_data <= src_data;
    end
  end

endmodule

// File: rtl/pipe_reg_elastic.sv
// Multi-lane elastic pipeline: PIPE valid/ready stages, flush, occupancy.
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int LANES    = 4,
  parameter int PIPE     = 4,
  parameter int OCC_W    = clog2(PIPE + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*BITWIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*BITWIDTH-1:0] out_data,
  input  logic                      flush,
  output logic [OCC_W-1:0]          occupancy
);

  logic [PIPE-1:0]                           w_vld;
  logic [PIPE-1:0]                           w_dst_rdy;
  logic [PIPE-1:0]                           w_stg_rdy;
  logic [PIPE-1:0]                           w_src_vld;
  logic [PIPE-1:0][LANES-1:0][BITWIDTH-1:0]  w_dat;
  logic [PIPE-1:0][LANES-1:0][BITWIDTH-1:0]  w_src_dat;
  logic                                      w_in_fire;
  logic                                      w_out_fire;
  logic [OCC_W-1:0]                          r_occ;

  // Stage ready is monotone toward the head (a ready stage implies every
  // upstream stage is ready), so the head accepts iff any stage is ready.
  assign in_ready   = (|w_stg_rdy) & ~flush;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_vld[PIPE-1] & out_ready;

  assign w_src_vld[0] = w_in_fire;
  assign w_src_dat[0] = in_data;

  for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
    if (gi > 0) begin : g_link
      assign w_src_vld[gi] = w_vld[gi-1];
      assign w_src_dat[gi] = w_dat[gi-1];
    end

    // Downstream ready in lookahead form: the tail drains, or some slot
    // beyond this one is empty. Built from valids only, so no comb chain.
    if (gi == PIPE-1) begin : g_tail
      assign w_dst_rdy[gi] = out_ready;
    end else begin : g_mid
      assign w_dst_rdy[gi] = out_ready | ~(&w_vld[PIPE-1:gi+1]);
    end

    pipe_elastic_stage #(
      .BITWIDTH (BITWIDTH),
      .LANES    (LANES)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .src_valid (w_src_vld[gi]),
      .src_data  (w_src_dat[gi]),
      .dst_ready (w_dst_rdy[gi]),
      .valid     (w_vld[gi]),
      .data      (w_dat[gi]),
      .ready     (w_stg_rdy[gi])
    );
  end

  assign out_valid = w_vld[PIPE-1];
  assign out_data  = w_dat[PIPE-1];
  assign occupancy = r_occ;

  // Occupancy tracks words in flight; always equals the count of set valids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_occ <= '0;
    else if (flush) r_occ <= '0;
    else            r_occ <= r_occ + OCC_W'(w_in_fire) - OCC_W'(w_out_fire);
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Self-checking bench for pipe_reg_elastic against a word-queue model.
module tb_pipe_reg_elastic;

  localparam int BITWIDTH = 8;
  localparam int LANES    = 4;
  localparam int PIPE     = 4;
  localparam int DW       = LANES * BITWIDTH;
  localparam int OCC_W    = $clog2(PIPE + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             flush;
  logic [OCC_W-1:0] occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: in-flight words, oldest first, each with its stage position.
  typedef struct {
    logic [DW-1:0] d;
    int            pos;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  pipe_reg_elastic #(
    .BITWIDTH (BITWIDTH),
    .LANES    (LANES),
    .PIPE     (PIPE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Head accepts when not flushing and either a slot is free or the tail drains.
  function automatic bit m_in_ready();
    return !flush && (q.size() < PIPE || out_ready);
  endfunction

  function automatic logic [DW-1:0] sword(input int k);
    logic [DW-1:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++) w[l*BITWIDTH +: BITWIDTH] = BITWIDTH'(LANES*k + LANES - l);
    return w;
  endfunction

  task automatic check_all();
    bit exp_ov;
    exp_ov = (q.size() > 0) && (q[0].pos == PIPE-1);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) chk("out_data", out_data, q[0].d);
    chk("occupancy", occupancy, q.size());
    chk("in_ready", in_ready, m_in_ready());
  endtask

  // Word k (k words ahead of it) moves from pos p if the tail drains or a
  // slot beyond p is still free.
  task automatic model_edge();
    bit acc;
    bit ofire;
    acc   = in_valid && m_in_ready();
    ofire = (q.size() > 0) && (q[0].pos == PIPE-1) && out_ready;
    if (!flush) begin
      for (int k = 0; k < q.size(); k++)
        if (q[k].pos < PIPE-1 && (out_ready || k < PIPE-1-q[k].pos)) q[k].pos++;
    end
    if (ofire) void'(q.pop_front());
    if (flush) q.delete();
    else if (acc) q.push_back('{d: in_data, pos: 0});
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int w;
    int nfire;
    int bub_exp[5];
    logic [DW-1:0] got[$];
    logic [DW-1:0] wv;

    bub_exp = '{1, 1, 2, 2, 3};

    // Reset with random inputs.
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("rel_out_data", out_data, 0);
    chk("rel_occ", occupancy, 0);

    // Streaming: 8 back-to-back words, each out PIPE cycles later.
    for (int k = 0; k < 12; k++) begin
      in_valid = (k < 8);
      in_data  = sword(k);
      step();
      chk("stream_valid", out_valid, (k >= PIPE-1) && (k < PIPE-1+8));
      if (k >= PIPE-1 && k < PIPE-1+8) chk("stream_data", out_data, sword(k-PIPE+1));
      if (k >= PIPE-1 && k <= 7) chk("stream_occ", occupancy, PIPE);
    end

    // Backpressure: offer 6 words with the tail stalled.
    out_ready = 1'b0; w = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; wv = 32'hB000_0000 + DW'(w); in_data = wv;
      #1;
      if (in_ready) w++;
      step();
    end
    chk("bp_accepted", w, 4);
    chk("bp_occ", occupancy, 4);
    chk("bp_hold_data", out_data, 32'hB000_0000);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1; nfire = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (w < 6); wv = 32'hB000_0000 + DW'(w); in_data = wv;
      #1;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (c < 6) nfire++;
      end
      if (in_valid && in_ready) w++;
      step();
    end
    chk("bp_no_gap", nfire, 6);
    chk("bp_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk("bp_order", got[i], 32'hB000_0000 + i);

    // Bubbles: alternate pushes with the tail stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      wv = 32'hC0DE_0000 + DW'(i); in_data = wv;
      step();
      chk("bubble_occ", occupancy, bub_exp[i]);
    end

    // Flush with a drainable tail word and a pending input.
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = $urandom();
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_tail_valid", out_valid, 1);
    chk("flush_tail_data", out_data, 32'hC0DE_0000);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_out_valid", out_valid, 0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;

    // Fill, then reset asynchronously between edges.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = $urandom();
      step();
    end
    chk("full_occ", occupancy, PIPE);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_occ", occupancy, 0);
    chk("async_out_data", out_data, 0);
    in_valid = 1'b0;
    chk("async_in_ready", in_ready, 1);
    @(posedge clk);
    q.delete();
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
